// File: rtl/uart_dbg_master.sv
// UART-to-bus debug master: 8N1 command bytes ('W'/'R' + addr [+ data]) drive a
// single-request bus port; responses (ACK, read data or NAK) are sent back serially.
module uart_dbg_master #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wren,
  output logic        m_rden,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        err
);
  localparam int DIV     = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(DIV);
  localparam int TO_CLKS = 255 * DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);

  typedef enum logic [2:0] {RX_HUNT, RX_START, RX_BITS, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} cmd_state_t;

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick, rx_done, rx_ferr;

  always_comb begin
    rx_next = rx_state;
    rx_tick = 1'b0;
    rx_done = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      RX_HUNT:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_M1) begin
        rx_tick = 1'b1;
        rx_next = rx_s2 ? RX_HUNT : RX_BITS;
      end
      RX_BITS:  if (rx_cnt == DIV_M1) begin
        rx_tick = 1'b1;
        if (rx_bit == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP:  if (rx_cnt == DIV_M1) begin
        rx_tick = 1'b1;
        rx_done = rx_s2;
        rx_ferr = !rx_s2;
        rx_next = rx_s2 ? RX_HUNT : RX_WAIT;
      end
      RX_WAIT:  if (rx_s2) rx_next = RX_HUNT;
      default:  rx_next = RX_HUNT;
    endcase
  end

  // Synchronizer resets low so a line held low through reset is never a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b000;
      rx_state <= RX_HUNT;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx};
      rx_state <= rx_next;
      rx_cnt   <= (rx_tick || rx_state == RX_HUNT || rx_state == RX_WAIT) ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      else if (rx_tick && rx_state == RX_BITS) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------- command FSM ----------------
  cmd_state_t    state, next;
  logic          op_wr, req, err_d, tx_load, tx_last, tx_busy;
  logic [1:0]    bcnt;
  logic [7:0]    bus_cnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   resp_sh;
  logic [2:0]    resp_cnt;

  always_comb begin
    next    = state;
    err_d   = rx_ferr;
    tx_load = 1'b0;
    case (state)
      IDLE: if (rx_done) begin
        if (rx_sh == 8'h57 || rx_sh == 8'h52) next = ADDR;
        else err_d = 1'b1;
      end
      ADDR, DATA: begin
        if (rx_done) begin
          if (bcnt == 2'd3) next = (state == ADDR && op_wr) ? DATA : BUS;
        end else if (tcnt == TO_M1) begin
          err_d = 1'b1;
          next  = IDLE;
        end
      end
      BUS: if (req && (m_ack || bus_cnt == 8'hff)) begin
        next = RESP;
        if (!m_ack) err_d = 1'b1;
      end
      RESP: begin
        // Loading on the final clock of the previous stop bit keeps bytes back-to-back.
        tx_load = (resp_cnt != 3'd0) && (!tx_busy || tx_last);
        if (resp_cnt == 3'd0 && tx_last) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      err      <= 1'b0;
      op_wr    <= 1'b0;
      req      <= 1'b0;
      bcnt     <= '0;
      bus_cnt  <= '0;
      tcnt     <= '0;
      resp_sh  <= '0;
      resp_cnt <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      state <= next;
      err   <= err_d;
      tcnt  <= (rx_done || !(state == ADDR || state == DATA)) ? '0 : tcnt + 1'b1;
      case (state)
        IDLE: if (rx_done) begin
          op_wr <= (rx_sh == 8'h57);
          bcnt  <= '0;
        end
        ADDR: if (rx_done) begin
          m_addr <= {m_addr[23:0], rx_sh};
          bcnt   <= bcnt + 1'b1;
        end
        DATA: if (rx_done) begin
          m_wdata <= {m_wdata[23:0], rx_sh};
          bcnt    <= bcnt + 1'b1;
        end
        BUS: begin
          if (!req) begin
            req     <= 1'b1;
            bus_cnt <= '0;
          end else if (m_ack) begin
            req      <= 1'b0;
            resp_sh  <= op_wr ? {8'h06, 24'h0} : m_rdata;
            resp_cnt <= op_wr ? 3'd1 : 3'd4;
          end else if (bus_cnt == 8'hff) begin
            req      <= 1'b0;
            resp_sh  <= {8'h15, 24'h0};
            resp_cnt <= 3'd1;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end
        RESP: if (tx_load) begin
          resp_sh  <= {resp_sh[23:0], 8'h00};
          resp_cnt <= resp_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  assign tx_last = tx_busy && tx_cnt == DIV_M1 && tx_bit == 4'd9;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, resp_sh[31:24], 1'b0};
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else tx_bit <= tx_bit + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign uart_tx = !tx_busy || tx_sh[0];
  assign m_wren  = req && op_wr;
  assign m_rden  = req && !op_wr;
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_dbg_master.sv
// Bench for uart_dbg_master: serial host driver, bus responder, serial decoder and
// a response model derived from the command protocol.
module tb_uart_dbg_master;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;

  logic        clk = 1'b0;
  logic        reset, uart_rx, uart_tx, m_wren, m_rden, m_ack, busy, err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  uart_dbg_master #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wren(m_wren), .m_rden(m_rden),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
  );

  int checks = 0, passed = 0;
  int cyc = 0, stop_cyc = 0;
  int err_cnt = 0, err_cyc = 0, busy_seen = 0, tx_act = 0, tx_ferr = 0;
  int n_req = 0, both_cnt = 0, unstable = 0, last_len = 0, hi = 0, ack_lat = 0, n_txstart = 0;
  logic [31:0] req_addr, req_wdata, rd_val;
  logic        req_wr, s, s_prev = 1'b0;
  logic [7:0]  tx_q[$];
  int          tx_st[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Event counters and bus responder: ack after ack_lat strobe cycles (0 = never).
  initial forever begin
    @(negedge clk);
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_seen++;
    if (!uart_tx) tx_act++;
    s = m_wren | m_rden;
    if (m_wren && m_rden) both_cnt++;
    if (s && !s_prev) begin
      n_req++; req_addr = m_addr; req_wdata = m_wdata; req_wr = m_wren; hi = 0;
    end
    if (s && (m_addr !== req_addr || m_wdata !== req_wdata)) unstable++;
    m_ack = 1'b0;
    m_rdata = $urandom;
    if (s) begin
      hi++;
      if (ack_lat > 0 && hi == ack_lat) begin m_ack = 1'b1; m_rdata = rd_val; end
    end
    if (!s && s_prev) last_len = hi;
    s_prev = s;
  end

  // Serial decoder for uart_tx, sampling mid-bit.
  initial begin
    int dcnt;
    logic [7:0] dsh;
    logic tx_prev;
    dcnt = -1; dsh = '0; tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) dcnt = -1;
      else if (dcnt < 0) begin
        if (tx_prev && !uart_tx) begin dcnt = 0; n_txstart++; tx_st.push_back(cyc); end
      end else begin
        dcnt++;
        if (dcnt == 5 && uart_tx) dcnt = -1;
        else if (dcnt >= 15 && dcnt <= 85 && (dcnt - 15) % 10 == 0) dsh = {uart_tx, dsh[7:1]};
        else if (dcnt == 95) begin
          if (uart_tx) tx_q.push_back(dsh); else tx_ferr++;
          dcnt = -1;
        end
      end
      tx_prev = uart_tx;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0; repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (DIV) @(negedge clk); end
    stop_cyc = cyc;
    uart_rx = stop; repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_done"}, busy, 0);
    repeat (30) @(negedge clk);
  endtask

  // Sends one command and checks bus transaction and response against the model.
  task automatic do_cmd(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int lat);
    int r0, e0;
    logic [7:0] exp_q[$];
    logic [7:0] got;
    r0 = n_req; e0 = err_cnt;
    ack_lat = lat; rd_val = rd;
    tx_q.delete(); tx_st.delete();
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    for (int k = 3; k >= 0; k--) send_byte(a[8*k +: 8], 1'b1);
    if (wr) for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8], 1'b1);
    wait_idle(tag);
    if (lat == 0) exp_q.push_back(8'h15);
    else if (wr) exp_q.push_back(8'h06);
    else for (int k = 3; k >= 0; k--) exp_q.push_back(8'((rd >> (8 * k)) & 32'hff));
    chk({tag, "_nreq"}, n_req - r0, 1);
    chk({tag, "_op"}, req_wr, wr);
    chk({tag, "_addr"}, req_addr, a);
    if (wr) chk({tag, "_wdata"}, req_wdata, d);
    chk({tag, "_strobe_len"}, last_len, (lat == 0) ? 256 : lat);
    chk({tag, "_err"}, err_cnt - e0, (lat == 0) ? 1 : 0);
    chk({tag, "_ntx"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 'x;
      if (i < tx_q.size()) got = tx_q[i];
      chk({tag, "_txbyte"}, got, exp_q[i]);
    end
    if (exp_q.size() == 4 && tx_st.size() == 4) chk({tag, "_b2b"}, tx_st[3] - tx_st[0], 3 * 10 * DIV);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, s0, n;
    reset = 1'b1; uart_rx = 1'b0; m_ack = 1'b0; m_rdata = '0; rd_val = '0;
    repeat (5) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_strobes", {m_wren, m_rden}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_busy_err", {busy, err}, 0);

    // Line low across reset release must not start a byte.
    reset = 1'b0;
    repeat (30) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("low_after_rst_err", err_cnt, 0);
    chk("low_after_rst_busy", busy_seen, 0);

    do_cmd("wr", 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h0, 3);
    do_cmd("rd", 1'b0, 32'h00001000, 32'h0, 32'hCAFEF00D, 2);
    do_cmd("bto", 1'b0, 32'h00000004, 32'h0, 32'h0, 0);

    // Unknown command byte, then a framing error.
    e0 = err_cnt; busy_seen = 0; tx_act = 0;
    send_byte(8'h41, 1'b1);
    repeat (20) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    repeat (50) @(negedge clk);
    chk("bad_err", err_cnt - e0, 2);
    chk("bad_busy", busy_seen, 0);
    chk("bad_tx", tx_act, 0);
    do_cmd("after_bad", 1'b1, $urandom, $urandom, 32'h0, 4);

    // Truncated command: timeout 255 bit-times after the last byte.
    r0 = n_req; e0 = err_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    s0 = stop_cyc;
    repeat (2600) @(negedge clk);
    chk("trunc_err", err_cnt - e0, 1);
    chk("trunc_when", (err_cyc - s0 >= 2555) && (err_cyc - s0 <= 2561), 1);
    chk("trunc_busy", busy, 0);
    chk("trunc_noreq", n_req - r0, 0);

    // Reset during the second byte of a read response.
    tx_q.delete(); tx_st.delete();
    ack_lat = 2; rd_val = 32'h13579BDF;
    s0 = n_txstart;
    send_byte(8'h52, 1'b1);
    for (int k = 3; k >= 0; k--) send_byte(8'h20 + 8'(k), 1'b1);
    n = 0;
    while (n_txstart < s0 + 2 && n < 3000) begin @(negedge clk); n++; end
    chk("rstmid_reached", n_txstart - s0, 2);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_tx", uart_tx, 1);
    chk("rstmid_strobes", {m_wren, m_rden, busy}, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (600) @(negedge clk);
    chk("rstmid_nbytes", tx_q.size(), 1);
    chk("rstmid_byte0", tx_q.size() > 0 ? tx_q[0] : 8'hxx, 8'h13);
    do_cmd("post_rst", 1'b0, $urandom, 32'h0, $urandom, 5);

    for (int t = 0; t < 5; t++)
      do_cmd("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(1, 20));

    chk("never_both_strobes", both_cnt, 0);
    chk("req_stable", unstable, 0);
    chk("tx_framing", tx_ferr, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_dbg_master.md
UART_DBG_MASTER -- requirements
Module: uart_dbg_master

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate; DIV = CLK_FREQ/BAUD_RATE is the number of clocks per bit, integer-truncated, and SHALL be >= 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port uart_rx, input, 1 bit: the serial command line from the host, idle high, asynchronous to clk.
REQ-006 The block SHALL have port uart_tx, output, 1 bit: the serial response line to the host, idle high.
REQ-007 The block SHALL have ports m_addr (output, 32 bits) and m_wdata (output, 32 bits): bus request address and write data.
REQ-008 The block SHALL have ports m_wren (output, 1 bit) and m_rden (output, 1 bit): bus write and read request strobes, held until acknowledged.
REQ-009 The block SHALL have ports m_rdata (input, 32 bits) and m_ack (input, 1 bit): read data, and request completion valid in the m_ack cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the command FSM is not in IDLE.
REQ-011 The block SHALL have port err, output, 1 bit: a one-cycle pulse on a framing error, unknown command, inter-byte timeout or bus timeout.

Function
REQ-012 The serial format SHALL be fixed 8N1: start 0, 8 data bits LSB first, 1 stop bit.
REQ-013 RX SHALL pass uart_rx through a 2-FF synchronizer, detect start on a 1->0 transition, re-check it low at DIV/2, then sample each data bit and the stop bit at DIV intervals from that point.
REQ-014 A stop bit sampled as 0 SHALL discard the byte, pulse err, and return RX to hunt for start only once the line is high.
REQ-015 The command FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-016 In IDLE: byte 0x57 ('W') -> ADDR with op=write; byte 0x52 ('R') -> ADDR with op=read; any other byte -> err pulse, stay in IDLE, no response.
REQ-017 ADDR SHALL collect 4 bytes MSB first into m_addr; after the 4th byte, write -> DATA, read -> BUS.
REQ-018 DATA SHALL collect 4 bytes MSB first into m_wdata, then -> BUS.
REQ-019 In ADDR/DATA, 255 bit-times (255*DIV clocks) without a completed byte SHALL pulse err and return to IDLE, discarding the partial command.
REQ-020 In BUS, m_wren or m_rden SHALL assert the cycle after entry, with m_addr/m_wdata stable, and deassert the cycle after m_ack=1 is sampled.
REQ-021 m_rdata SHALL be captured in the m_ack cycle.
REQ-022 m_ack in a cycle where no request is asserted SHALL be ignored.
REQ-023 If 256 clocks elapse with a request asserted and no m_ack, the strobe SHALL drop, err SHALL pulse, and the response SHALL be the single byte 0x15 (NAK).
REQ-024 In RESP: a write success SHALL send 0x06 (ACK); a read success SHALL send the 4 captured m_rdata bytes MSB first, back-to-back with no idle bits; after the last stop bit the FSM SHALL return to IDLE.
REQ-025 Bytes fully received while in BUS or RESP SHALL be discarded silently, with no err pulse.
REQ-026 m_wren and m_rden SHALL never be high in the same cycle.

Reset
REQ-027 While reset=1: uart_tx=1, m_wren=0, m_rden=0, m_addr=0, m_wdata=0, busy=0, err=0, FSM=IDLE, RX in hunt, all counters 0.
REQ-028 Reset asserted mid-byte or mid-transaction SHALL abort immediately with no pending request and no further response bytes.
REQ-029 After reset deasserts, a line already low SHALL NOT be taken as a start bit until it has first been seen high.

Verification
Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000, DIV=10.
REQ-030 Bench SHALL cover write: serial 57 12 34 56 78 DE AD BE EF, m_ack 3 cycles after m_wren -> one m_wren pulse-train with m_addr=0x12345678, m_wdata=0xDEADBEEF, then TX byte 0x06.
REQ-031 Bench SHALL cover read: serial 52 00 00 10 00, m_ack with m_rdata=0xCAFEF00D -> m_rden asserted with m_addr=0x00001000, then TX bytes CA FE F0 0D.
REQ-032 Bench SHALL cover bus timeout: 52 00 00 00 04 with m_ack tied 0 -> m_rden high exactly 256 cycles, one err pulse, then TX 0x15.
REQ-033 Bench SHALL cover bad input: byte 0x41, then a byte with stop=0 -> two err pulses, busy stays 0, no TX activity, and a following valid write completes normally.
REQ-034 Bench SHALL cover truncation: 57 01 02, then silence 2600 clocks -> err pulse at 255 bit-times after the last byte, busy=0, no bus request issued.
REQ-035 Bench SHALL cover reset: assert reset during the second response byte of a read -> uart_tx=1 at once, no further bytes, and the next command is processed correctly.
